// File: rtl/puf_challenge_sequencer.sv
// Challenge sequencer for a one-bit RO PUF: walks RESP_BITS consecutive challenges,
// times the settle/measure window of each, and packs the sampled bits into one word.
module puf_challenge_sequencer #(
  parameter int RESP_BITS = 16,
  parameter int SETTLE    = 4,
  parameter int WINDOW    = 1024,
  parameter int WIN_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           seed,
  input  logic                 abort,
  output logic [7:0]           challenge,
  output logic                 puf_rst,
  input  logic                 puf_out,
  output logic                 busy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] resp_data,
  output logic [2:0]           dbg_state
);

  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WIN_W-1:0]     phase_q, phase_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           chal_d;
  logic [RESP_BITS-1:0] data_d;
  logic                 puf_rst_d, busy_d, valid_d;

  // Handshake: resp_data is presented with resp_valid held high and stable until an
  // edge where resp_ready is also high; that edge completes the transfer. resp_ready
  // outside DONE has no effect, and abort overrides a same-cycle transfer.

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    chal_d  = challenge;
    data_d  = resp_data;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          phase_d = '0;
          idx_d   = '0;
          chal_d  = seed;
          data_d  = '0;
        end
      end
      ST_SETTLE: begin
        if (phase_q == WIN_W'(SETTLE - 1)) begin
          state_d = ST_MEASURE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + WIN_W'(1);
        end
      end
      ST_MEASURE: begin
        if (phase_q == WIN_W'(WINDOW - 1)) begin
          state_d = ST_SAMPLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + WIN_W'(1);
        end
      end
      ST_SAMPLE: begin
        data_d[idx_q] = puf_out;
        phase_d       = '0;
        if (idx_q == IDX_W'(RESP_BITS - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          idx_d   = idx_q + IDX_W'(1);
          chal_d  = challenge + 8'd1;
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort drops the partial word and wins over both capture and hand-off.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      phase_d = '0;
      idx_d   = '0;
      data_d  = '0;
    end

    puf_rst_d = !(state_d == ST_MEASURE || state_d == ST_SAMPLE);
    busy_d    = (state_d != ST_IDLE);
    valid_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      idx_q      <= '0;
      challenge  <= 8'd0;
      resp_data  <= '0;
      puf_rst    <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      challenge  <= chal_d;
      resp_data  <= data_d;
      puf_rst    <= puf_rst_d;
      busy       <= busy_d;
      resp_valid <= valid_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed + randomized bench for puf_challenge_sequencer; expectations come from a
// timeline model (edges since acceptance -> bit/offset) rather than from the RTL.
module tb_puf_challenge_sequencer;

  localparam int S = 2;
  localparam int W = 8;
  localparam int R = 4;
  localparam int P = S + W + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [7:0]   seed;
  logic         abort;
  logic [7:0]   challenge;
  logic         puf_rst;
  logic         puf_out;
  logic         busy;
  logic         resp_valid;
  logic         resp_ready;
  logic [R-1:0] resp_data;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  puf_challenge_sequencer #(
    .RESP_BITS(R), .SETTLE(S), .WINDOW(W), .WIN_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .abort(abort),
    .challenge(challenge), .puf_rst(puf_rst), .puf_out(puf_out), .busy(busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .dbg_state(dbg_state)
  );

  // PUF stand-in: response equals challenge LSB
  assign puf_out = challenge[0];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_chal(input logic [7:0] s, input int k);
    int b;
    b = k / P;
    if (b > R - 1) b = R - 1;
    return 8'(int'(s) + b);
  endfunction

  function automatic logic [R-1:0] m_data(input logic [7:0] s, input int k);
    logic [R-1:0] d;
    logic [7:0]   c;
    int n;
    d = '0;
    n = k / P;
    if (n > R) n = R;
    for (int b = 0; b < n; b++) begin
      c    = 8'(int'(s) + b);
      d[b] = c[0];
    end
    return d;
  endfunction

  function automatic logic m_rst(input int k);
    if (k >= R * P) return 1'b1;
    return ((k % P) < S);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [R-1:0] exp_data);
    chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
    chk({tag, "_valid"}, 64'(resp_valid), 64'(1'b0));
    chk({tag, "_puf_rst"}, 64'(puf_rst), 64'(1'b1));
    chk({tag, "_data"}, 64'(resp_data), 64'(exp_data));
  endtask

  // k = rising edges since the start-accepting edge
  task automatic chk_timeline(input logic [7:0] s, input int k);
    chk($sformatf("chal_k%0d", k), 64'(challenge), 64'(m_chal(s, k)));
    chk($sformatf("rst_k%0d", k), 64'(puf_rst), 64'(m_rst(k)));
    chk($sformatf("busy_k%0d", k), 64'(busy), 64'(1'b1));
    chk($sformatf("valid_k%0d", k), 64'(resp_valid), 64'(k >= R * P));
    chk($sformatf("data_k%0d", k), 64'(resp_data), 64'(m_data(s, k)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [7:0] s);
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
    seed  = 8'h00;
  endtask

  // Full request: optional stray start at edge poke_k, hold cycles of backpressure,
  // and optional start alongside resp_ready in DONE.
  task automatic full_request(input logic [7:0] s, input int poke_k, input int hold,
                              input logic start_at_ready);
    logic [R-1:0] exp_word;
    exp_word = m_data(s, R * P);
    accept(s);
    for (int k = 0; k < R * P; k++) begin
      chk_timeline(s, k);
      start = (k == poke_k);
      seed  = 8'h00;
      @(negedge clk);
    end
    start = 1'b0;
    chk_timeline(s, R * P);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid), 64'(1'b1));
      chk("bp_data", 64'(resp_data), 64'(exp_word));
    end
    resp_ready = 1'b1;
    start      = start_at_ready;
    @(negedge clk);
    resp_ready = 1'b0;
    start      = 1'b0;
    chk_idle("handoff", exp_word);
    @(negedge clk);
    chk_idle("post_handoff", exp_word);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rs;
    int         rh;
    reset = 1'b0; start = 1'b0; seed = 8'h00; abort = 1'b0; resp_ready = 1'b0;
    #12;
    chk("rst_chal", 64'(challenge), 64'h0);
    chk_idle("reset", '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("idle_after_rst", '0);

    // basic run with backpressure
    full_request(8'hFE, -1, 20, 1'b0);
    chk("basic_word", 64'(resp_data), 64'h0A);

    // stray start in MEASURE of bit 1, then start together with resp_ready
    full_request(8'hFE, P + S + 3, 2, 1'b1);
    chk("ignored_start_word", 64'(resp_data), 64'h0A);

    // abort during MEASURE of bit 2
    accept(8'h10);
    for (int k = 0; k <= 2 * P + S + 3; k++) begin
      chk_timeline(8'h10, k);
      abort = (k == 2 * P + S + 3);
      @(negedge clk);
    end
    abort = 1'b0;
    chk_idle("abort", '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle("after_abort", '0);
    end
    full_request(8'h03, -1, 1, 1'b0);
    chk("post_abort_word", 64'(resp_data), 64'h05);

    // async reset mid-SETTLE of bit 1, between clock edges
    accept(8'h41);
    for (int k = 0; k <= P; k++) begin
      chk_timeline(8'h41, k);
      @(negedge clk);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("async_chal", 64'(challenge), 64'h0);
    chk_idle("async_rst", '0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle("idle_after_async", '0);
    end

    // randomized requests
    for (int r = 0; r < 4; r++) begin
      rs = 8'($urandom_range(0, 255));
      rh = $urandom_range(0, 6);
      full_request(rs, -1, rh, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
